escalonador_so: RTL and testbench

Parametrised OS control block for the multi-process core: it extends BIOS/OS/user-process selection with N processes, round-robin next-process suggestion and time-slice preemption. It sits between the control unit (HALT, Set_ctx, Set_pid_0) and the instruction/data memory address logic (Sel_BIOS, id_proc). It raises a quantum interrupt when a user process exhausts its slice.

---
 rtl/escalonador_pkg.sv | 16 +
 rtl/escalonador_so_rr_seletor.sv | 29 ++
 rtl/escalonador_so.sv | 129 ++++++++++++
 tb/tb_escalonador_so.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/escalonador_pkg.sv
// Shared types and defaults for the multi-process OS scheduler block.
package escalonador_pkg;

  typedef enum logic [1:0] {
    BIOS    = 2'd0,
    SO      = 2'd1,
    USER    = 2'd2,
    PREEMPT = 2'd3
  } estado_t;

  localparam int PID_OS      = 0;
  localparam int NPROC_DEF   = 4;
  localparam int QUANTUM_DEF = 1024;
  localparam int QW_DEF      = 16;

endpackage

// File: rtl/escalonador_so_rr_seletor.sv
// Combinational round-robin scan: first ready user PID after base_pid,
// wrapping past the OS slot, with base_pid itself as the last candidate.
module rr_seletor
  import escalonador_pkg::*;
#(
  parameter int NPROC = NPROC_DEF,
  parameter int PID_W = $clog2(NPROC)
) (
  input  logic [NPROC-1:0] mask,
  input  logic [PID_W-1:0] base_pid,
  output logic [PID_W-1:0] prox_pid,
  output logic             nenhum_pronto
);

  always_comb begin : scan
    int idx;
    idx           = 0;
    prox_pid      = '0;
    nenhum_pronto = 1'b1;
    for (int off = 1; off <= NPROC; off++) begin
      idx = (int'(base_pid) + off) % NPROC;
      if (nenhum_pronto && (idx != PID_OS) && mask[idx]) begin
        prox_pid      = PID_W'(idx);
        nenhum_pronto = 1'b0;
      end
    end
  end

endmodule

// File: rtl/escalonador_so.sv
// OS control block: BIOS/OS/user selection, time-slice preemption and
// registered round-robin suggestion of the next user process.
module escalonador_so
  import escalonador_pkg::*;
#(
  parameter int NPROC   = NPROC_DEF,
  parameter int PID_W   = $clog2(NPROC),
  parameter int QUANTUM = QUANTUM_DEF,
  parameter int QW      = QW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             HALT,
  input  logic             Set_ctx,
  input  logic             Set_pid_0,
  input  logic [PID_W-1:0] id_proc_atual,
  input  logic [NPROC-1:0] proc_pronto,
  output logic             Sel_BIOS,
  output logic [PID_W-1:0] id_proc,
  output logic             irq_quantum,
  output logic [PID_W-1:0] prox_pid,
  output logic             nenhum_pronto
);

  estado_t          estado_q, estado_d;
  logic             sel_bios_q, sel_bios_d;
  logic [PID_W-1:0] id_proc_q, id_proc_d;
  logic             irq_q, irq_d;
  logic [QW-1:0]    contador_q, contador_d;
  logic [PID_W-1:0] ultimo_pid_q, ultimo_pid_d;
  logic [PID_W-1:0] prox_pid_q, prox_pid_d;
  logic             nenhum_q, nenhum_d;

  logic [PID_W-1:0] rr_prox;
  logic             rr_nenhum;

  rr_seletor #(
    .NPROC (NPROC),
    .PID_W (PID_W)
  ) u_rr (
    .mask          (proc_pronto),
    .base_pid      (ultimo_pid_q),
    .prox_pid      (rr_prox),
    .nenhum_pronto (rr_nenhum)
  );

  always_comb begin
    estado_d     = estado_q;
    sel_bios_d   = sel_bios_q;
    id_proc_d    = id_proc_q;
    irq_d        = irq_q;
    contador_d   = contador_q;
    ultimo_pid_d = ultimo_pid_q;
    prox_pid_d   = rr_prox;
    nenhum_d     = rr_nenhum;

    case (estado_q)
      BIOS: begin
        sel_bios_d = 1'b1;
        if (HALT) begin
          estado_d   = SO;
          sel_bios_d = 1'b0;
          id_proc_d  = PID_W'(PID_OS);
        end
      end
      SO: begin
        if (Set_pid_0) begin
          estado_d = SO;
        end else if (Set_ctx && (id_proc_atual != PID_W'(PID_OS))) begin
          estado_d     = USER;
          id_proc_d    = id_proc_atual;
          ultimo_pid_d = id_proc_atual;
          contador_d   = QW'(QUANTUM - 1);
        end
      end
      USER: begin
        // Saturating decrement; expiry is detected on the cycle the counter reads zero.
        contador_d = (contador_q != '0) ? contador_q - QW'(1) : '0;
        if (Set_pid_0 || HALT) begin
          estado_d  = SO;
          id_proc_d = PID_W'(PID_OS);
        end else if (contador_q == '0) begin
          estado_d = PREEMPT;
          irq_d    = 1'b1;
        end
      end
      PREEMPT: begin
        if (Set_pid_0 || HALT) begin
          estado_d  = SO;
          id_proc_d = PID_W'(PID_OS);
          irq_d     = 1'b0;
        end
      end
      default: begin
        estado_d   = BIOS;
        sel_bios_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q     <= BIOS;
      sel_bios_q   <= 1'b1;
      id_proc_q    <= PID_W'(PID_OS);
      irq_q        <= 1'b0;
      contador_q   <= '0;
      ultimo_pid_q <= PID_W'(PID_OS);
      prox_pid_q   <= '0;
      nenhum_q     <= 1'b1;
    end else begin
      estado_q     <= estado_d;
      sel_bios_q   <= sel_bios_d;
      id_proc_q    <= id_proc_d;
      irq_q        <= irq_d;
      contador_q   <= contador_d;
      ultimo_pid_q <= ultimo_pid_d;
      prox_pid_q   <= prox_pid_d;
      nenhum_q     <= nenhum_d;
    end
  end

  assign Sel_BIOS      = sel_bios_q;
  assign id_proc       = id_proc_q;
  assign irq_quantum   = irq_q;
  assign prox_pid      = prox_pid_q;
  assign nenhum_pronto = nenhum_q;

endmodule

// File: tb/tb_escalonador_so.sv
// Directed bench for escalonador_so with NPROC=4 and an 8-cycle quantum.
module tb_escalonador_so;

  localparam int NPROC   = 4;
  localparam int PID_W   = 2;
  localparam int QUANTUM = 8;
  localparam int QW      = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             HALT;
  logic             Set_ctx;
  logic             Set_pid_0;
  logic [PID_W-1:0] id_proc_atual;
  logic [NPROC-1:0] proc_pronto;
  logic             Sel_BIOS;
  logic [PID_W-1:0] id_proc;
  logic             irq_quantum;
  logic [PID_W-1:0] prox_pid;
  logic             nenhum_pronto;

  int checks   = 0;
  int failures = 0;

  escalonador_so #(
    .NPROC   (NPROC),
    .PID_W   (PID_W),
    .QUANTUM (QUANTUM),
    .QW      (QW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .HALT          (HALT),
    .Set_ctx       (Set_ctx),
    .Set_pid_0     (Set_pid_0),
    .id_proc_atual (id_proc_atual),
    .proc_pronto   (proc_pronto),
    .Sel_BIOS      (Sel_BIOS),
    .id_proc       (id_proc),
    .irq_quantum   (irq_quantum),
    .prox_pid      (prox_pid),
    .nenhum_pronto (nenhum_pronto)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of control inputs, let the edge happen, then return them to idle.
  task automatic applyStimulus(input logic h, input logic c, input logic p, input logic [PID_W-1:0] pid);
    HALT          = h;
    Set_ctx       = c;
    Set_pid_0     = p;
    id_proc_atual = pid;
    @(posedge clk);
    #1;
    HALT      = 1'b0;
    Set_ctx   = 1'b0;
    Set_pid_0 = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    HALT          = 1'b0;
    Set_ctx       = 1'b0;
    Set_pid_0     = 1'b0;
    id_proc_atual = '0;
    proc_pronto   = 4'b0000;

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_sel_bios", Sel_BIOS, 1);
    checkOutput("rst_id_proc", id_proc, 0);
    checkOutput("rst_irq", irq_quantum, 0);
    checkOutput("rst_prox", prox_pid, 0);
    checkOutput("rst_nenhum", nenhum_pronto, 1);

    reset = 1'b1;
    applyStimulus(0, 1, 1, 2);
    checkOutput("bios_ignore_sel", Sel_BIOS, 1);
    checkOutput("bios_ignore_id", id_proc, 0);

    applyStimulus(1, 0, 0, 0);
    checkOutput("halt_sel_bios", Sel_BIOS, 0);
    checkOutput("halt_id_proc", id_proc, 0);
    checkOutput("halt_irq", irq_quantum, 0);

    applyStimulus(1, 0, 0, 0);
    checkOutput("so_halt_ignored_sel", Sel_BIOS, 0);
    checkOutput("so_halt_ignored_id", id_proc, 0);

    applyStimulus(0, 1, 0, 0);
    checkOutput("so_ctx_pid0", id_proc, 0);

    applyStimulus(0, 1, 1, 2);
    checkOutput("so_pid0_beats_ctx", id_proc, 0);

    // Full slice: irq rises exactly QUANTUM edges after the sampled Set_ctx.
    applyStimulus(0, 1, 0, 2);
    checkOutput("ctx2_id", id_proc, 2);
    checkOutput("ctx2_irq", irq_quantum, 0);
    for (int i = 1; i < QUANTUM; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("slice_irq_low", irq_quantum, 0);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("slice_irq_high", irq_quantum, 1);
    checkOutput("preempt_id_kept", id_proc, 2);
    applyStimulus(0, 0, 0, 0);
    checkOutput("irq_held", irq_quantum, 1);
    applyStimulus(0, 1, 0, 3);
    checkOutput("preempt_ctx_ignored_id", id_proc, 2);
    checkOutput("preempt_ctx_ignored_irq", irq_quantum, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("ack_id", id_proc, 0);
    checkOutput("ack_irq", irq_quantum, 0);

    // Early return to the OS, then a fresh slice must be full length.
    applyStimulus(0, 1, 0, 2);
    checkOutput("early_ctx_id", id_proc, 2);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("early_ret_id", id_proc, 0);
    checkOutput("early_ret_irq", irq_quantum, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("so_no_irq", irq_quantum, 0);
    end
    applyStimulus(0, 1, 0, 3);
    checkOutput("reload_id", id_proc, 3);
    for (int i = 1; i < QUANTUM; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("reload_irq_low", irq_quantum, 0);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("reload_irq_high", irq_quantum, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("preempt_halt_irq", irq_quantum, 0);
    checkOutput("preempt_halt_id", id_proc, 0);
    checkOutput("preempt_halt_sel", Sel_BIOS, 0);

    // Round-robin suggestion.
    proc_pronto = 4'b1010;
    applyStimulus(0, 1, 0, 1);
    checkOutput("ctx1_id", id_proc, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("user_halt_id", id_proc, 0);
    checkOutput("rr_after1_prox", prox_pid, 3);
    checkOutput("rr_after1_nenhum", nenhum_pronto, 0);
    applyStimulus(0, 1, 0, 3);
    checkOutput("ctx3_id", id_proc, 3);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rr_wrap_prox", prox_pid, 1);
    checkOutput("rr_wrap_nenhum", nenhum_pronto, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("ret_id", id_proc, 0);
    proc_pronto = 4'b1000;
    applyStimulus(0, 0, 0, 0);
    checkOutput("rr_self_prox", prox_pid, 3);
    checkOutput("rr_self_nenhum", nenhum_pronto, 0);
    proc_pronto = 4'b0001;
    applyStimulus(0, 0, 0, 0);
    checkOutput("rr_none_prox", prox_pid, 0);
    checkOutput("rr_none_nenhum", nenhum_pronto, 1);

    // Reset in the middle of a slice.
    proc_pronto = 4'b1100;
    applyStimulus(0, 1, 0, 2);
    checkOutput("mid_ctx_id", id_proc, 2);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0);
    reset = 1'b1;
    checkOutput("mid_rst_sel", Sel_BIOS, 1);
    checkOutput("mid_rst_id", id_proc, 0);
    checkOutput("mid_rst_irq", irq_quantum, 0);
    checkOutput("mid_rst_prox", prox_pid, 0);
    checkOutput("mid_rst_nenhum", nenhum_pronto, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_ultimo_prox", prox_pid, 2);
    applyStimulus(0, 1, 0, 3);
    checkOutput("bios_ctx_ignored_sel", Sel_BIOS, 1);
    checkOutput("bios_ctx_ignored_id", id_proc, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("second_boot_sel", Sel_BIOS, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
